// File: rtl/nvram_backup_ctrl.sv
// ---------------------------------------------------------------------------
// nvram_backup_ctrl
//   Copies the backup NVRAM to and from the mounted .SAV image, one 512-byte
//   SD sector at a time, using the user_io sd_lba / sd_rd / sd_wr / sd_ack
//   handshake. A mount with a non-empty image loads the whole image into the
//   NVRAM buffer. Completing that load pulses bk_reset so the core restarts
//   with the restored save. A rising edge on save_req writes the buffer back
//   to the image.
//
//   Optional feature (macro NVRAM_AUTOSAVE_EN): core writes to the NVRAM mark
//   it dirty. After AUTOSAVE_QUIET cycles with no further writes, the block
//   issues its own save. When the macro is undefined, i_nvram_we is ignored.
//
// Ports
//   i_clk_sys      system clock
//   i_reset        synchronous active-high reset
//   i_img_mounted  image mount strobe/level from user_io
//   i_img_size     mounted image size in bytes (0 = nothing usable)
//   i_download     ROM download in progress; its rising edge disables backup
//   i_save_req     OSD "write save RAM"; rising edge requests a save
//   i_nvram_we     core NVRAM write strobe (dirty tracking, autosave only)
//   i_sd_ack       user_io sector acknowledge
//   o_sd_lba       sector address (upper bits zero, low bits = o_sec_idx)
//   o_sd_rd        sector read request (load)
//   o_sd_wr        sector write request (save)
//   o_sec_idx      current sector; high address bits of the dpram port B
//   o_bk_ena       a save image is mounted and usable
//   o_bk_busy      transfer in progress
//   o_bk_reset     one-cycle pulse after a completed load
//   o_bk_err       sticky; the last transfer timed out waiting for sd_ack
// ---------------------------------------------------------------------------
module nvram_backup_ctrl #(
    parameter int unsigned SECTORS        = 16,
    parameter logic [23:0] ACK_TIMEOUT    = 24'd8000000,
    parameter logic [23:0] AUTOSAVE_QUIET = 24'd4000000,
    localparam int unsigned SW            = (SECTORS > 1) ? $clog2(SECTORS) : 1
) (
    input  logic          i_clk_sys,
    input  logic          i_reset,
    input  logic          i_img_mounted,
    input  logic [31:0]   i_img_size,
    input  logic          i_download,
    input  logic          i_save_req,
    input  logic          i_nvram_we,
    input  logic          i_sd_ack,
    output logic [31:0]   o_sd_lba,
    output logic          o_sd_rd,
    output logic          o_sd_wr,
    output logic [SW-1:0] o_sec_idx,
    output logic          o_bk_ena,
    output logic          o_bk_busy,
    output logic          o_bk_reset,
    output logic          o_bk_err
);

    localparam logic [SW-1:0] LAST_SEC = SW'(SECTORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Registered edge detectors. Each edge becomes a one-cycle pulse and is
    // acted on in the following cycle. Reset loads the delay registers with
    // the live inputs, so a level that is already high is not taken as an
    // edge.
    // ------------------------------------------------------------------
    logic r_mnt_d, r_dl_d, r_save_d, r_ack_d;
    logic r_mnt_rise, r_size_nz, r_dl_rise, r_save_rise, r_ack_rise, r_ack_fall;

    always_ff @(posedge i_clk_sys) begin
        r_mnt_d  <= i_img_mounted;
        r_dl_d   <= i_download;
        r_save_d <= i_save_req;
        r_ack_d  <= i_sd_ack;
        if (i_reset) begin
            r_mnt_rise  <= 1'b0;
            r_size_nz   <= 1'b0;
            r_dl_rise   <= 1'b0;
            r_save_rise <= 1'b0;
            r_ack_rise  <= 1'b0;
            r_ack_fall  <= 1'b0;
        end else begin
            r_mnt_rise  <= i_img_mounted & ~r_mnt_d;
            r_size_nz   <= |i_img_size;
            r_dl_rise   <= i_download & ~r_dl_d;
            r_save_rise <= i_save_req & ~r_save_d;
            r_ack_rise  <= i_sd_ack & ~r_ack_d;
            r_ack_fall  <= ~i_sd_ack & r_ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t        r_state, w_state_n;
    logic [SW-1:0] r_sec, w_sec_n;
    logic          r_rd, w_rd_n;
    logic          r_wr, w_wr_n;
    logic          r_busy, w_busy_n;
    logic          r_bkrst, w_bkrst_n;
    logic          r_err, w_err_n;
    logic          r_ena, w_ena_n;
    logic          r_load_q, w_load_q_n;   // load waiting for IDLE
    logic          r_pend, w_pend_n;       // save edge seen while busy
    logic          r_is_load, w_is_load_n; // direction of current operation
    logic [23:0]   r_cnt, w_cnt_n;         // sd_ack wait counter
    logic          w_start_save;
    logic          w_auto_req;

    // ------------------------------------------------------------------
    // Autosave dirty tracking
    // ------------------------------------------------------------------
`ifdef NVRAM_AUTOSAVE_EN
    logic        r_dirty;
    logic [23:0] r_qcnt;   // cycles since the last NVRAM write, saturating

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_dirty <= 1'b0;
            r_qcnt  <= 24'd0;
        end else if (i_nvram_we) begin
            // A write during a transfer re-dirties the buffer and restarts
            // the quiet period.
            r_dirty <= 1'b1;
            r_qcnt  <= 24'd0;
        end else begin
            if (w_start_save || (r_state == S_DONE && r_is_load))
                r_dirty <= 1'b0;
            if (r_qcnt != AUTOSAVE_QUIET)
                r_qcnt <= r_qcnt + 24'd1;
        end
    end

    assign w_auto_req = r_dirty & r_ena & (r_state == S_IDLE) & (r_qcnt == AUTOSAVE_QUIET);
`else
    logic w_unused;
    assign w_unused   = ^{i_nvram_we, AUTOSAVE_QUIET};
    assign w_auto_req = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n    = r_state;
        w_sec_n      = r_sec;
        w_rd_n       = r_rd;
        w_wr_n       = r_wr;
        w_busy_n     = r_busy;
        w_bkrst_n    = 1'b0;
        w_err_n      = r_err;
        w_ena_n      = r_ena;
        w_load_q_n   = r_load_q;
        w_pend_n     = r_pend;
        w_is_load_n  = r_is_load;
        w_cnt_n      = r_cnt;
        w_start_save = 1'b0;

        // Enable tracking. A download edge overrides a mount edge in the
        // same cycle, and a queued load is discarded.
        if (r_mnt_rise) begin
            w_ena_n    = r_size_nz;
            w_load_q_n = r_size_nz;
        end
        if (r_dl_rise) begin
            w_ena_n    = 1'b0;
            w_load_q_n = 1'b0;
        end

        // While busy, save edges collapse into one pending save.
        if (r_state != S_IDLE && r_save_rise)
            w_pend_n = 1'b1;

        unique case (r_state)
            S_IDLE: begin
                if (w_load_q_n) begin
                    // A load takes priority. A save requested in the
                    // same cycle is dropped.
                    w_load_q_n  = 1'b0;
                    w_pend_n    = 1'b0;
                    w_is_load_n = 1'b1;
                    w_sec_n     = '0;
                    w_busy_n    = 1'b1;
                    w_err_n     = 1'b0;
                    w_state_n   = S_REQ;
                end else if ((r_save_rise || r_pend || w_auto_req) && w_ena_n) begin
                    w_start_save = 1'b1;
                    w_pend_n     = 1'b0;
                    w_is_load_n  = 1'b0;
                    w_sec_n      = '0;
                    w_busy_n     = 1'b1;
                    w_err_n      = 1'b0;
                    w_state_n    = S_REQ;
                end else begin
                    w_pend_n = 1'b0;
                end
            end
            S_REQ: begin
                w_rd_n    = r_is_load;
                w_wr_n    = ~r_is_load;
                w_cnt_n   = 24'd0;
                w_state_n = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (r_ack_rise) begin
                    w_rd_n    = 1'b0;
                    w_wr_n    = 1'b0;
                    w_state_n = S_WAIT_LO;
                end else if (r_cnt == ACK_TIMEOUT - 24'd1) begin
                    // The request was held for ACK_TIMEOUT cycles without an
                    // acknowledge. Abort the transfer with no bk_reset.
                    w_rd_n    = 1'b0;
                    w_wr_n    = 1'b0;
                    w_err_n   = 1'b1;
                    w_busy_n  = 1'b0;
                    w_state_n = S_IDLE;
                end else begin
                    w_cnt_n = r_cnt + 24'd1;
                end
            end
            S_WAIT_LO: begin
                if (r_ack_fall) begin
                    if (r_sec == LAST_SEC) begin
                        w_state_n = S_DONE;
                    end else if (!w_ena_n) begin
                        // A download started: the image is no longer ours.
                        w_busy_n  = 1'b0;
                        w_state_n = S_IDLE;
                    end else begin
                        w_sec_n   = r_sec + SW'(1);
                        w_state_n = S_REQ;
                    end
                end
            end
            S_DONE: begin
                w_busy_n  = 1'b0;
                w_bkrst_n = r_is_load;
                w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_sec     <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_bkrst   <= 1'b0;
            r_err     <= 1'b0;
            r_ena     <= 1'b0;
            r_load_q  <= 1'b0;
            r_pend    <= 1'b0;
            r_is_load <= 1'b0;
            r_cnt     <= 24'd0;
        end else begin
            r_state   <= w_state_n;
            r_sec     <= w_sec_n;
            r_rd      <= w_rd_n;
            r_wr      <= w_wr_n;
            r_busy    <= w_busy_n;
            r_bkrst   <= w_bkrst_n;
            r_err     <= w_err_n;
            r_ena     <= w_ena_n;
            r_load_q  <= w_load_q_n;
            r_pend    <= w_pend_n;
            r_is_load <= w_is_load_n;
            r_cnt     <= w_cnt_n;
        end
    end

    assign o_sd_lba   = 32'(r_sec);
    assign o_sd_rd    = r_rd;
    assign o_sd_wr    = r_wr;
    assign o_sec_idx  = r_sec;
    assign o_bk_ena   = r_ena;
    assign o_bk_busy  = r_busy;
    assign o_bk_reset = r_bkrst;
    assign o_bk_err   = r_err;

endmodule

// File: tb/tb_nvram_backup_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for nvram_backup_ctrl (SECTORS=16, ACK_TIMEOUT=100,
// AUTOSAVE_QUIET=50).
//
// The bench keeps a transaction-level model: a queue of the sector requests
// (direction and lba) each directed step should produce. A per-cycle
// compare process pops that queue on every new sd_rd/sd_wr request. It also
// checks the structural rules: rd and wr never both high, sd_lba equals
// sec_idx with its upper bits zero, and bk_reset lasting a single cycle.
// Literal expectations pin the timings: reset values, save latency,
// timeout length, and the bk_reset position.
// ---------------------------------------------------------------------------
module tb_nvram_backup_ctrl;

    localparam int SECTORS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mnt = 1'b0;
    logic [31:0] size = 32'd0;
    logic        dl = 1'b0;
    logic        save = 1'b0;
    logic        we = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] lba;
    logic        rd, wr;
    logic [3:0]  sec_idx;
    logic        ena, busy, bkrst, err;

    nvram_backup_ctrl #(
        .SECTORS        (SECTORS),
        .ACK_TIMEOUT    (24'd100),
        .AUTOSAVE_QUIET (24'd50)
    ) dut (
        .i_clk_sys     (clk),
        .i_reset       (rst),
        .i_img_mounted (mnt),
        .i_img_size    (size),
        .i_download    (dl),
        .i_save_req    (save),
        .i_nvram_we    (we),
        .i_sd_ack      (ack),
        .o_sd_lba      (lba),
        .o_sd_rd       (rd),
        .o_sd_wr       (wr),
        .o_sec_idx     (sec_idx),
        .o_bk_ena      (ena),
        .o_bk_busy     (busy),
        .o_bk_reset    (bkrst),
        .o_bk_err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- model: expected sector requests ----------------
    typedef struct {
        bit wr;
        int lba;
    } req_t;
    req_t exp_q[$];

    task automatic push_xfer(input bit is_wr, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            req_t r;
            r.wr  = is_wr;
            r.lba = i;
            exp_q.push_back(r);
        end
    endtask

    // ---------------- per-cycle compare process ----------------
    logic prev_req = 1'b0;
    logic prev_rst = 1'b0;
    int   n_bkrst = 0;
    int   last_bkrst_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
            prev_rst = 1'b0;
        end else begin
            chk("rd_wr_exclusive", {31'd0, rd & wr}, 32'd0);
            chk("lba_matches_idx", lba, {28'd0, sec_idx});
            if ((rd | wr) && !prev_req) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL req_unexpected: got wr=%0b lba=%0d, expected no request (cycle %0d)",
                             wr, lba, cyc);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    chk("req_is_write", {31'd0, wr}, {31'd0, e.wr});
                    chk("req_lba", lba, e.lba);
                end
            end
            if (bkrst) begin
                n_bkrst++;
                last_bkrst_cyc = cyc;
                chk("bk_reset_one_cycle", {31'd0, prev_rst}, 32'd0);
            end
            prev_req = rd | wr;
            prev_rst = bkrst;
        end
    end

    // ---------------- SD acknowledge responder ----------------
    bit   ack_en = 1'b1;
    logic ack_prev = 1'b0;
    int   last_fall_cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && (rd | wr) && !ack_prev && ack_en) begin
                int w;
                repeat (10) @(posedge clk);
                #1 ack = 1'b1;
                w = 0;
                while ((rd | wr) && w < 50) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                if (w >= 50) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ack_drop: got request still high after 50 cycles, expected drop");
                end
                repeat (2) @(posedge clk);
                #1 ack = 1'b0;
                last_fall_cyc = cyc;
            end
            ack_prev = rd | wr;
        end
    end

    // ---------------- helpers ----------------
    // Waits for a transfer to start, then for bk_busy to stay low for 40 cycles.
    task automatic run_idle(input string nm);
        int k;
        int q;
        k = 0;
        while (!busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        q = 0;
        k = 0;
        while (q < 40 && k < 5000) begin
            @(negedge clk);
            q = busy ? 0 : q + 1;
            k++;
        end
        if (k >= 5000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_idle: got busy after 5000 cycles, expected idle", nm);
        end
    endtask

    // Waits for sd_wr high at a given lba (-1 = any lba).
    task automatic wait_wr(input string nm, input int want);
        int k;
        k = 0;
        while (!(wr && (want < 0 || int'(lba) == want)) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_wait: got no sd_wr at lba %0d, expected one", nm, want);
        end
    endtask

    task automatic do_load(input string nm);
        int b0;
        mnt = 1'b0;
        @(negedge clk);
        b0 = n_bkrst;
        push_xfer(1'b0, 0, SECTORS - 1);
        size = 32'd8192;
        mnt  = 1'b1;
        run_idle(nm);
        chk({nm, "_all_reqs"}, exp_q.size(), 0);
        chk({nm, "_bk_reset_count"}, n_bkrst - b0, 1);
        chk({nm, "_bk_ena"}, {31'd0, ena}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1 ms, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int p;
        int b0;
        int d;

        // Reset, with the mount already high: no false edge afterwards.
        mnt  = 1'b1;
        size = 32'd8192;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_lba", lba, 0);
        chk("rst_rd", {31'd0, rd}, 0);
        chk("rst_wr", {31'd0, wr}, 0);
        chk("rst_idx", {28'd0, sec_idx}, 0);
        chk("rst_ena", {31'd0, ena}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_bk_reset", {31'd0, bkrst}, 0);
        chk("rst_err", {31'd0, err}, 0);
        repeat (30) @(negedge clk);
        chk("no_false_mount_ena", {31'd0, ena}, 0);
        chk("no_false_mount_busy", {31'd0, busy}, 0);

        // Load 16 sectors on mount.
        do_load("load1");
        chk("bk_reset_after_last_fall", last_bkrst_cyc - last_fall_cyc, 3);

        // A zero-size mount disables backup, so save does nothing.
        mnt = 1'b0;
        @(negedge clk);
        size = 32'd0;
        mnt  = 1'b1;
        repeat (5) @(negedge clk);
        chk("zero_size_ena", {31'd0, ena}, 0);
        save = 1'b1;
        repeat (60) @(negedge clk);
        chk("zero_size_no_busy", {31'd0, busy}, 0);
        save = 1'b0;

        // Normal save: latency, 16 writes, no bk_reset.
        do_load("load2");
        b0 = n_bkrst;
        push_xfer(1'b1, 0, SECTORS - 1);
        save = 1'b1;
        p = cyc;
        wait_wr("save_lat", -1);
        chk("save_latency", cyc - p, 3);
        run_idle("save1");
        save = 1'b0;
        chk("save1_all_reqs", exp_q.size(), 0);
        chk("save1_no_bk_reset", n_bkrst - b0, 0);
        chk("save1_busy_low", {31'd0, busy}, 0);
        chk("save1_err", {31'd0, err}, 0);

        // Timeout: no acknowledge.
        @(negedge clk);
        ack_en = 1'b0;
        b0 = n_bkrst;
        push_xfer(1'b1, 0, 0);
        save = 1'b1;
        wait_wr("tmo", 0);
        p = cyc;
        d = 0;
        while (wr && d < 300) begin
            @(negedge clk);
            d++;
        end
        chk("timeout_length", cyc - p, 100);
        chk("timeout_err", {31'd0, err}, 1);
        chk("timeout_busy", {31'd0, busy}, 0);
        chk("timeout_no_bk_reset", n_bkrst - b0, 0);
        save   = 1'b0;
        ack_en = 1'b1;
        repeat (3) @(negedge clk);
        // A later save clears the error.
        push_xfer(1'b1, 0, SECTORS - 1);
        save = 1'b1;
        wait_wr("err_clear", 0);
        chk("err_cleared_on_start", {31'd0, err}, 0);
        run_idle("save2");
        save = 1'b0;
        chk("save2_all_reqs", exp_q.size(), 0);

        // A download during sector 5 ends the save after that sector.
        @(negedge clk);
        b0 = n_bkrst;
        push_xfer(1'b1, 0, 5);
        save = 1'b1;
        wait_wr("dl", 5);
        dl = 1'b1;
        run_idle("dl");
        chk("dl_all_reqs", exp_q.size(), 0);
        chk("dl_ena", {31'd0, ena}, 0);
        chk("dl_no_bk_reset", n_bkrst - b0, 0);
        save = 1'b0;
        dl   = 1'b0;

        // Two extra save edges during one save merge into a single repeat.
        do_load("load3");
        b0 = n_bkrst;
        push_xfer(1'b1, 0, SECTORS - 1);
        push_xfer(1'b1, 0, SECTORS - 1);
        save = 1'b1;
        wait_wr("merge_a", 3);
        save = 1'b0;
        @(negedge clk);
        save = 1'b1;
        wait_wr("merge_b", 8);
        save = 1'b0;
        @(negedge clk);
        save = 1'b1;
        run_idle("merge");
        save = 1'b0;
        chk("merge_all_reqs", exp_q.size(), 0);
        chk("merge_no_bk_reset", n_bkrst - b0, 0);

        // Core NVRAM writes.
        @(negedge clk);
`ifdef NVRAM_AUTOSAVE_EN
        push_xfer(1'b1, 0, SECTORS - 1);
`endif
        p  = cyc;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        repeat (29) @(negedge clk);
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
`ifdef NVRAM_AUTOSAVE_EN
        wait_wr("autosave", 0);
        d = cyc - p;
        chk("autosave_start_window", {31'd0, (d >= 77 && d <= 83)}, 1);
        run_idle("autosave");
        repeat (200) @(negedge clk);
        chk("autosave_all_reqs", exp_q.size(), 0);
`else
        repeat (200) @(negedge clk);
        chk("nvram_we_ignored_busy", {31'd0, busy}, 0);
        chk("nvram_we_ignored_reqs", exp_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
